// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way set-associative write-through, no-write-allocate read cache
//
// Sits between the MEM stage and the SRAM controller. Read hits complete in the
// request cycle; read misses fetch a 64-bit line; writes always go to SRAM and
// patch the cached copy when the word is resident.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_rd_en       load request from MEM stage
//   mem_wr_en       store request from MEM stage (wins over mem_rd_en)
//   address, wdata  byte address ([2] word, [8:3] index, [18:9] tag) and store data
//   rdata, ready    load data; ready low freezes the pipeline
//   sram_rd_en      line read request to SRAM controller
//   sram_wr_en      word write request to SRAM controller
//   sram_address    passthrough of address
//   sram_wdata      passthrough of wdata
//   sram_rdata      64-bit line from SRAM ([31:0] word 0, [63:32] word 1)
//   sram_ready      one-cycle completion strobe from SRAM controller
module cache_controller #(
  parameter int SET_BITS = 6,
  parameter int TAG_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int SETS    = 1 << SET_BITS;
  localparam int TAG_LSB = 3 + SET_BITS;
  localparam int TAG_MSB = TAG_LSB + TAG_BITS - 1;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;
  state_t state;

  logic [TAG_BITS-1:0] tag0  [SETS];
  logic [TAG_BITS-1:0] tag1  [SETS];
  logic [63:0]         data0 [SETS];
  logic [63:0]         data1 [SETS];
  logic [SETS-1:0]     valid0;
  logic [SETS-1:0]     valid1;
  logic [SETS-1:0]     lru;      // 1 = way1 is least recently used

  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic                word_sel;
  logic                hit0;
  logic                hit1;
  logic                hit;
  logic [63:0]         hit_line;
  logic [31:0]         hit_word;
  logic [31:0]         sram_word;
  logic                victim;

  // Bits outside word/index/tag do not take part in the lookup.
  logic unused_addr;
  assign unused_addr = ^{address[31:TAG_MSB+1], address[1:0]};

  assign idx      = address[TAG_LSB-1:3];
  assign tag      = address[TAG_MSB:TAG_LSB];
  assign word_sel = address[2];

  assign hit0      = valid0[idx] && (tag0[idx] == tag);
  assign hit1      = valid1[idx] && (tag1[idx] == tag);
  assign hit       = hit0 || hit1;
  assign hit_line  = hit0 ? data0[idx] : data1[idx];
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign sram_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

  // Fill an empty way before evicting; the LRU bit value is the way number to evict.
  assign victim = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

  assign sram_address = address;
  assign sram_wdata   = wdata;

  always_comb begin
    ready = 1'b1;
    rdata = 32'd0;
    case (state)
      IDLE: begin
        if (mem_wr_en) begin
          ready = 1'b0;
        end else if (mem_rd_en) begin
          ready = hit;
          rdata = hit ? hit_word : 32'd0;
        end
      end
      RD_MISS: begin
        ready = sram_ready;
        rdata = sram_ready ? sram_word : 32'd0;
      end
      WR: begin
        ready = sram_ready;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  // Control state, valid and LRU bits; all clear asynchronously so a reset
  // mid-miss drops the SRAM request at once and leaves nothing valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sram_rd_en <= 1'b0;
      sram_wr_en <= 1'b0;
      valid0     <= '0;
      valid1     <= '0;
      lru        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_wr_en) begin
            state      <= WR;
            sram_wr_en <= 1'b1;
          end else if (mem_rd_en) begin
            if (hit) begin
              lru[idx] <= hit0;
            end else begin
              state      <= RD_MISS;
              sram_rd_en <= 1'b1;
            end
          end
        end
        RD_MISS: begin
          if (sram_ready) begin
            state      <= IDLE;
            sram_rd_en <= 1'b0;
            if (victim) valid1[idx] <= 1'b1;
            else        valid0[idx] <= 1'b1;
            lru[idx] <= ~victim;
          end
        end
        WR: begin
          if (sram_ready) begin
            state      <= IDLE;
            sram_wr_en <= 1'b0;
            if (hit) lru[idx] <= hit0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays need no reset: they are only observed through valid bits.
  always_ff @(posedge clk) begin
    if (!rst && state == RD_MISS && sram_ready) begin
      if (victim) begin
        tag1[idx]  <= tag;
        data1[idx] <= sram_rdata;
      end else begin
        tag0[idx]  <= tag;
        data0[idx] <= sram_rdata;
      end
    end else if (!rst && state == WR && sram_ready && hit) begin
      if (hit0) begin
        if (word_sel) data0[idx][63:32] <= wdata;
        else          data0[idx][31:0]  <= wdata;
      end else begin
        if (word_sel) data1[idx][63:32] <= wdata;
        else          data1[idx][31:0]  <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized self-checking bench for cache_controller
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int total;
  int bad;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_rd_en   (sram_rd_en),
    .sram_wr_en   (sram_wr_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: backing memory plus per-set contents of both ways.
  logic [31:0] mem [logic [31:0]];
  bit          m_valid [64][2];
  logic [9:0]  m_tag   [64][2];
  logic [31:0] m_data  [64][2][2];
  bit          m_lru   [64];   // 1 = way1 is LRU

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 64; s++) begin
      m_valid[s][0] = 0;
      m_valid[s][1] = 0;
      m_lru[s]      = 0;
    end
  endtask

  // One complete request: drive it, play the SRAM controller with a random
  // latency, check handshake and data, then advance the model.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd, input string nm);
    int          idx;
    logic [9:0]  tg;
    int          w;
    int          hw;
    int          victim;
    logic [31:0] line_a;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    int          lat;
    int          cnt;
    int          done_cyc;
    bit          done;
    bit          saw_rd;
    bit          saw_wr;

    idx    = int'(a[8:3]);
    tg     = a[18:9];
    w      = int'(a[2]);
    line_a = {a[31:3], 3'b000};
    hw     = -1;
    for (int k = 0; k < 2; k++)
      if (m_valid[idx][k] && m_tag[idx][k] == tg) hw = k;
    exp_rd = (hw >= 0) ? m_data[idx][hw][w] : mem_rd(a);

    @(negedge clk);
    mem_rd_en  = rd;
    mem_wr_en  = wr;
    address    = a;
    wdata      = wd;
    sram_ready = 1'b0;
    sram_rdata = {$urandom, $urandom};
    lat        = $urandom_range(0, 3);
    cnt        = 0;
    done       = 0;
    done_cyc   = -1;
    saw_rd     = 0;
    saw_wr     = 0;
    got_rd     = '0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        sram_ready = 1'b0;
        sram_rdata = {$urandom, $urandom};
      end
      saw_rd |= sram_rd_en;
      saw_wr |= sram_wr_en;
      if (sram_rd_en || sram_wr_en) begin
        if (cnt == lat) begin
          sram_ready = 1'b1;
          sram_rdata = {mem_rd(line_a + 32'd4), mem_rd(line_a)};
        end
        cnt++;
      end
      #1;
      if (cyc == 0) check({nm, "_addr"}, sram_address, a);
      if (ready) begin
        done     = 1;
        done_cyc = cyc;
        got_rd   = rdata;
      end
    end
    check({nm, "_done"}, done, 1);
    check({nm, "_wr_req"}, saw_wr, wr);
    check({nm, "_rd_req"}, saw_rd, rd && !wr && hw < 0);
    if (rd && !wr) begin
      check({nm, "_rdata"}, got_rd, exp_rd);
      check({nm, "_hit_now"}, done_cyc == 0, hw >= 0);
    end
    @(posedge clk);

    if (wr) begin
      mem[{a[31:2], 2'b00}] = wd;
      if (hw >= 0) begin
        m_data[idx][hw][w] = wd;
        m_lru[idx] = (hw == 0);
      end
    end else if (rd) begin
      if (hw >= 0) begin
        m_lru[idx] = (hw == 0);
      end else begin
        victim = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : (m_lru[idx] ? 1 : 0));
        m_valid[idx][victim]   = 1;
        m_tag[idx][victim]     = tg;
        m_data[idx][victim][0] = mem_rd(line_a);
        m_data[idx][victim][1] = mem_rd(line_a + 32'd4);
        m_lru[idx] = (victim == 0);
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    sram_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    sram_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Assert reset while a read miss is waiting on SRAM.
  task automatic reset_mid_read(input logic [31:0] a);
    @(negedge clk);
    mem_rd_en  = 1'b1;
    mem_wr_en  = 1'b0;
    address    = a;
    sram_ready = 1'b0;
    @(negedge clk);
    check("mid_rd_en_pending", sram_rd_en, 1);
    check("mid_ready_low", ready, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", sram_rd_en, 0);
    mem_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  logic [31:0] a;
  int          r;
  logic [31:0] tag_pool [4];
  logic [31:0] idx_pool [4];

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    address    = '0;
    wdata      = '0;
    sram_rdata = '0;
    sram_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_rdata", rdata, 0);
    check("rst_sram_rd_en", sram_rd_en, 0);
    check("rst_sram_wr_en", sram_wr_en, 0);

    // Line fill then hit on the other word.
    mem[32'h400] = 32'hAAAA_AAAA;
    mem[32'h404] = 32'hBBBB_BBBB;
    do_op(1, 0, 32'h400, 0, "t1_miss");
    do_op(1, 0, 32'h404, 0, "t1_hit");

    // Fill set 0 with tags 1 and 2, touch tag 1, then tag 3 evicts tag 2.
    do_op(1, 0, 32'h200, 0, "t2_fill1");
    do_op(1, 0, 32'h200, 0, "t2_touch");
    do_op(1, 0, 32'h600, 0, "t2_evict");
    do_op(1, 0, 32'h200, 0, "t2_keep");
    do_op(1, 0, 32'h400, 0, "t2_gone");

    // Write-through hit updates the cached word.
    do_op(0, 1, 32'h404, 32'h1234_5678, "t3_wr");
    do_op(1, 0, 32'h404, 0, "t3_rd");

    // Write miss does not allocate.
    do_op(0, 1, 32'h800, 32'hCAFE_F00D, "t4_wr");
    do_op(1, 0, 32'h800, 0, "t4_rd");
    go_idle();

    // Reset during a miss clears everything.
    reset_mid_read(32'hA00);
    do_op(1, 0, 32'h400, 0, "t5_rd");

    // Simultaneous read and write takes the write path.
    do_op(1, 1, 32'h404, 32'h0BAD_BEEF, "t6_both");
    do_op(1, 0, 32'h404, 0, "t6_rd");

    // Random traffic over a small address pool, including the index wrap at set 63.
    tag_pool[0] = 32'd0;  tag_pool[1] = 32'd1;  tag_pool[2] = 32'd2;  tag_pool[3] = 32'd1023;
    idx_pool[0] = 32'd0;  idx_pool[1] = 32'd1;  idx_pool[2] = 32'd62; idx_pool[3] = 32'd63;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a = (tag_pool[$urandom_range(0, 3)] << 9) | (idx_pool[$urandom_range(0, 3)] << 3)
          | (32'($urandom_range(0, 1)) << 2);
      r = $urandom_range(0, 9);
      if (r < 6)      do_op(1, 0, a, 0, "rnd_rd");
      else if (r < 9) do_op(0, 1, a, $urandom, "rnd_wr");
      else            do_op(1, 1, a, $urandom, "rnd_both");
      if ($urandom_range(0, 7) == 0) go_idle();
    end
    go_idle();
    @(negedge clk);
    check("end_ready", ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
